// File: rtl/cla_pkg.sv
// Shared constants and the 4-bit lookahead helper for the pipelined CLA subtractor.
package cla_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned HALF      = WIDTH_DEF / 2;

  localparam logic [WIDTH_DEF-1:0] SAT_POS = {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam logic [WIDTH_DEF-1:0] SAT_NEG = {1'b1, {(WIDTH_DEF-1){1'b0}}};

  // Carries c[0..4] of a 4-bit group; c[4] with cin=0 is the group generate.
  function automatic logic [4:0] lookahead4(input logic [3:0] g, input logic [3:0] p,
                                            input logic cin);
    logic [4:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & cin);
    return c;
  endfunction

endpackage

// File: rtl/cla_sub_32_bit_if.sv
// Valid/ready operand and result bundle for cla_sub_32_bit.
interface cla_sub_32_bit_if
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/cla_16_bit.sv
// Two-level carry-lookahead adder built from 4-bit groups: sum = x + y + cin.
module cla_16_bit
  import cla_pkg::*;
#(
  parameter int unsigned W = HALF
) (
  output logic [W-1:0] sum,
  output logic         cout,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin
);
  localparam int unsigned NG = W / 4;

  logic [W-1:0]  g, p, c;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   gc;
  logic [4:0]    t;

  always_comb begin
    g  = x & y;
    p  = x ^ y;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    t  = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      t     = lookahead4(g[4*k +: 4], p[4*k +: 4], 1'b0);
      gg[k] = t[4];
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    for (int unsigned k = 0; k < NG; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int unsigned k = 0; k < NG; k++) begin
      t            = lookahead4(g[4*k +: 4], p[4*k +: 4], gc[k]);
      c[4*k +: 4]  = t[3:0];
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[NG];
endmodule

// File: rtl/cla_sub_32_bit.sv
// Two-stage pipelined subtractor diff = a - b - bin with borrow, overflow and zero flags.
// Optional SUB_SAT_EN: signed saturation of diff on overflow, applied in stage 2.
module cla_sub_32_bit
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  cla_sub_32_bit_if.slave  bus
);
  localparam int unsigned H = WIDTH / 2;

  logic             adv1, adv2;
  logic             s1_valid;
  logic [H-1:0]     s1_lo, s1_a_hi, s1_nb_hi;
  logic             s1_c;
  logic [WIDTH-1:0] nb;
  logic             cin_lo;
  logic [H-1:0]     lo_sum, hi_sum;
  logic             lo_cout, hi_cout;
  logic [WIDTH-1:0] raw, res;
  logic             a_msb, b_msb, ovf_c;

  assign adv2         = !bus.out_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  // a - b - bin == a + ~b + ~bin; the final carry is the inverted borrow.
  assign nb     = ~bus.b;
  assign cin_lo = ~bus.bin;

  cla_16_bit #(.W(H)) u_lo (
    .sum (lo_sum),
    .cout(lo_cout),
    .x   (bus.a[H-1:0]),
    .y   (nb[H-1:0]),
    .cin (cin_lo)
  );

  cla_16_bit #(.W(H)) u_hi (
    .sum (hi_sum),
    .cout(hi_cout),
    .x   (s1_a_hi),
    .y   (s1_nb_hi),
    .cin (s1_c)
  );

  always_comb begin
    raw   = {hi_sum, s1_lo};
    a_msb = s1_a_hi[H-1];
    b_msb = ~s1_nb_hi[H-1];
    ovf_c = (a_msb != b_msb) && (raw[WIDTH-1] != a_msb);
    res   = raw;
`ifdef SUB_SAT_EN
    if (ovf_c) res = a_msb ? SAT_NEG : SAT_POS;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_a_hi  <= '0;
      s1_nb_hi <= '0;
      s1_c     <= 1'b0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_lo    <= lo_sum;
        s1_a_hi  <= bus.a[WIDTH-1:H];
        s1_nb_hi <= nb[WIDTH-1:H];
        s1_c     <= lo_cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.diff      <= '0;
      bus.bout      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.zero      <= 1'b0;
    end else if (adv2) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.diff <= res;
        bus.bout <= ~hi_cout;
        bus.ovf  <= ovf_c;
        bus.zero <= (res == '0);
      end
    end
  end
endmodule

// File: tb/tb_cla_sub_32_bit.sv
// Scoreboard bench for cla_sub_32_bit: directed vectors, stall, random and reset-mid-flight phases.
module tb_cla_sub_32_bit;
  import cla_pkg::*;

  localparam int unsigned W = WIDTH_DEF;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } resp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    resp_t        rsp;
  } dvec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cla_sub_32_bit_if #(.WIDTH(W)) bus ();

  cla_sub_32_bit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  resp_t       q[$];
  dvec_t       dirv[12];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned mode = 0;
  int unsigned cyc = 0;
  logic        saw_stall = 1'b0;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic dvec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                               input logic [W-1:0] d, input logic bo, input logic ov,
                               input logic z);
    dvec_t v;
    v.a = a; v.b = b; v.bin = bin;
    v.rsp.diff = d; v.rsp.bout = bo; v.rsp.ovf = ov; v.rsp.zero = z;
    return v;
  endfunction

  function automatic resp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] t;
    resp_t r;
    t      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    r.diff = t[W-1:0];
    r.bout = t[W];
    r.ovf  = (a[W-1] != b[W-1]) && (r.diff[W-1] != a[W-1]);
`ifdef SUB_SAT_EN
    if (r.ovf) r.diff = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    r.zero = (r.diff == '0);
    return r;
  endfunction

  // Monitor: every cycle a result is presented it must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.in_ready) saw_stall = 1'b1;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check_val("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          check_val("result", {bus.diff, bus.bout, bus.ovf, bus.zero}, q[0]);
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = !(cyc >= 3 && cyc <= 6);
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                      input resp_t rsp);
    logic accepted;
    accepted     = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(rsp);
        accepted = 1'b1;
      end
      tick();
      if (accepted) break;
    end
    bus.in_valid = 1'b0;
    if (!accepted) check_val("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    check_val("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned lat;
    logic [W-1:0] ra, rb;
    logic rbin;

    dirv[0]  = mk(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    dirv[1]  = mk(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    dirv[2]  = mk(32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    dirv[5]  = mk(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    dirv[6]  = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    dirv[8]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    dirv[9]  = mk(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 32'h0001_FFFF, 1'b1, 1'b0, 1'b0);
    dirv[11] = mk(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 32'hDEAD_BEED, 1'b0, 1'b0, 1'b0);
`ifdef SUB_SAT_EN
    dirv[3]  = mk(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    dirv[4]  = mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    dirv[7]  = mk(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    dirv[10] = mk(32'h1234_5678, 32'h8765_4321, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`else
    dirv[3]  = mk(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    dirv[4]  = mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    dirv[7]  = mk(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    dirv[10] = mk(32'h1234_5678, 32'h8765_4321, 1'b0, 32'h8ACF_1357, 1'b1, 1'b1, 1'b0);
`endif

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_diff", 64'(bus.diff), 64'd0);
    check_val("rst_flags", 64'({bus.bout, bus.ovf, bus.zero}), 64'd0);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Latency: single transfer, count rising edges until out_valid.
    mode = 0;
    send(dirv[0].a, dirv[0].b, dirv[0].bin, dirv[0].rsp);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 10);
    check_val("latency", 64'(lat), 64'd2);
    @(posedge clk);
    #1;
    drain();

    for (int i = 0; i < 12; i++) send(dirv[i].a, dirv[i].b, dirv[i].bin, dirv[i].rsp);
    drain();

    // Eight back-to-back transfers with the consumer stalled in cycles 3-6.
    mode          = 1;
    cyc           = 1;
    bus.out_ready = 1'b1;
    saw_stall     = 1'b0;
    for (int i = 0; i < 8; i++) send(dirv[i+4].a, dirv[i+4].b, dirv[i+4].bin, dirv[i+4].rsp);
    drain();
    check_val("in_ready_dropped", 64'(saw_stall), 64'd1);

    mode = 2;
    for (int i = 0; i < 300; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom_range(0, 1));
      send(ra, rb, rbin, model(ra, rb, rbin));
    end
    mode = 0;
    drain();

    // Fill both stages under stall, then reset mid-flight.
    mode          = 3;
    bus.out_ready = 1'b0;
    send(dirv[1].a, dirv[1].b, dirv[1].bin, dirv[1].rsp);
    send(dirv[4].a, dirv[4].b, dirv[4].bin, dirv[4].rsp);
    @(negedge clk);
    check_val("full_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("midrst_diff", 64'(bus.diff), 64'd0);
    q.delete();
    mode = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("post_rst_idle", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(dirv[2].a, dirv[2].b, dirv[2].bin, dirv[2].rsp);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
